arbitro_resta: RTL

Round-robin arbiter and sequencer that shares a single `resta` subtractor instance between two requesters in the FPGA controller. Each requester offers an operand pair over a valid/ready handshake. The block grants one request at a time, feeds the operands to the subtractor, and registers the difference with status flags. It then holds the result on a valid/ready output port until the consumer takes it.

---
 rtl/arbitro_resta.sv | 126 ++++++++++++
 1 files changed

// File: rtl/arbitro_resta.sv
// arbitro_resta: round-robin sharing of one resta subtractor between
// two valid/ready requesters; the result is held until consumed.
module resta #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S
);
  assign S = A - B;
endmodule

module arbitro_resta #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_borrow,
  output logic             res_zero,
  input  logic             res_ready
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] w_s;
  logic             r_cur_id;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_data;
  logic             r_id;
  logic             r_borrow;
  logic             r_zero;
  logic             w_any;
  logic             w_gnt_id;
  logic             w_accept;

  // Contention goes to the requester that did not win last time.
  assign w_any    = req0_valid | req1_valid;
  assign w_gnt_id = (req0_valid & req1_valid) ? ~r_last_grant
                                              : req1_valid;
  assign w_accept = (r_state == IDLE) & w_any;

  resta #(.WIDTH(WIDTH)) u_resta (
    .A(r_op_a),
    .B(r_op_b),
    .S(w_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = CALC;
      CALC:    w_next = HOLD;
      HOLD:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ready is gated by rst_n so it is low throughout reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        req0_ready = w_any & rst_n & ~w_gnt_id;
        req1_ready = w_any & rst_n & w_gnt_id;
      end
      HOLD:    res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_cur_id     <= 1'b0;
      r_last_grant <= 1'b1;
      r_data       <= '0;
      r_id         <= 1'b0;
      r_borrow     <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a       <= w_gnt_id ? req1_a : req0_a;
        r_op_b       <= w_gnt_id ? req1_b : req0_b;
        r_cur_id     <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end
      if (r_state == CALC) begin
        r_data   <= w_s;
        r_id     <= r_cur_id;
        r_borrow <= r_op_a < r_op_b;
        r_zero   <= w_s == '0;
      end
    end
  end

  assign res_data   = r_data;
  assign res_id     = r_id;
  assign res_borrow = r_borrow;
  assign res_zero   = r_zero;
endmodule
